// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry stall hold buffer
// and redirect handling. Optional performance counters under `IF_PERF_CNT_EN.
module if_fetch_stage #(
    parameter int              PC_W     = 12,
    parameter int              INSTR_W  = 19,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallIFID,
    input  logic               flushIFID,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirectPc,
    output logic               imemReq,
    output logic [PC_W-1:0]    imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    output logic [INSTR_W-1:0] instrIFOut,
    output logic [PC_W-1:0]    pcPlusOneIFOut,
    output logic               validIFOut
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]        fetchCnt,
    output logic [15:0]        discardCnt
`endif
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_next;
    logic [PC_W-1:0]     pc_plus_one;
    logic [PC_W-1:0]     discard_addr;
    logic [INSTR_W-1:0]  buf_instr;
    logic [PC_W-1:0]     buf_pc_plus_one;
    logic                ack_seen;
    logic                fetch_accept;
    logic                fetch_drop;

    assign pc_plus_one = pc + PC_W'(1);

    // State register plus all datapath registers of the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            discard_addr    <= '0;
            buf_instr       <= '0;
            buf_pc_plus_one <= '0;
            instrIFOut      <= '0;
            pcPlusOneIFOut  <= '0;
            validIFOut      <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;

            if (state == FETCH && redirect && !ack_seen)
                discard_addr <= pc;

            if (state == FETCH && ack_seen && !redirect && stallIFID) begin
                buf_instr       <= imemData;
                buf_pc_plus_one <= pc_plus_one;
            end

            // Flush outranks stall; a redirect or missing response loads a bubble.
            if (flushIFID) begin
                instrIFOut     <= '0;
                pcPlusOneIFOut <= '0;
                validIFOut     <= 1'b0;
            end else if (!stallIFID) begin
                if (redirect) begin
                    validIFOut <= 1'b0;
                end else begin
                    unique case (state)
                        FETCH: begin
                            if (ack_seen) begin
                                instrIFOut     <= imemData;
                                pcPlusOneIFOut <= pc_plus_one;
                                validIFOut     <= 1'b1;
                            end else begin
                                validIFOut <= 1'b0;
                            end
                        end
                        HOLD: begin
                            instrIFOut     <= buf_instr;
                            pcPlusOneIFOut <= buf_pc_plus_one;
                            validIFOut     <= 1'b1;
                        end
                        default: validIFOut <= 1'b0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect)
            pc_next = redirectPc;
        else if (state == FETCH && ack_seen)
            pc_next = pc_plus_one;

        unique case (state)
            FETCH: begin
                if (redirect)
                    state_next = ack_seen ? FETCH : DISCARD;
                else if (ack_seen && stallIFID)
                    state_next = HOLD;
                else
                    state_next = FETCH;
            end
            HOLD: begin
                if (redirect || !stallIFID)
                    state_next = FETCH;
                else
                    state_next = HOLD;
            end
            DISCARD: begin
                if (!redirect && ack_seen)
                    state_next = FETCH;
                else
                    state_next = DISCARD;
            end
            default: state_next = FETCH;
        endcase
    end

    // Ack only counts while a request is outstanding, so HOLD and reset ignore it.
    always_comb begin
        imemReq      = 1'b0;
        imemAddr     = pc;
        if (!rst) begin
            unique case (state)
                FETCH:   imemReq = 1'b1;
                DISCARD: begin
                    imemReq  = 1'b1;
                    imemAddr = discard_addr;
                end
                default: imemReq = 1'b0;
            endcase
        end
        ack_seen     = imemAck && imemReq;
        fetch_accept = ack_seen && (state == FETCH) && !redirect;
        fetch_drop   = ack_seen && (((state == FETCH) && redirect) || (state == DISCARD));
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCnt   <= '0;
            discardCnt <= '0;
        end else begin
            if (fetch_accept)
                fetchCnt <= fetchCnt + 16'd1;
            if (fetch_drop)
                discardCnt <= discardCnt + 16'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_accept ^ fetch_drop;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage: memory model returns data = address,
// with either zero-wait acks or acks driven cycle by cycle from the stimulus.
module tb_if_fetch_stage;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 19;

    logic               clk;
    logic               rst;
    logic               stallIFID;
    logic               flushIFID;
    logic               redirect;
    logic [PC_W-1:0]    redirectPc;
    logic               imemReq;
    logic [PC_W-1:0]    imemAddr;
    logic               imemAck;
    logic [INSTR_W-1:0] imemData;
    logic [INSTR_W-1:0] instrIFOut;
    logic [PC_W-1:0]    pcPlusOneIFOut;
    logic               validIFOut;
`ifdef IF_PERF_CNT_EN
    logic [15:0]        fetchCnt;
    logic [15:0]        discardCnt;
`endif

    logic autoAck;
    logic ackVal;
    int   compared;
    int   mismatched;

    assign imemAck  = autoAck ? imemReq : ackVal;
    assign imemData = INSTR_W'(imemAddr);

    if_fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(12'h000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallIFID      (stallIFID),
        .flushIFID      (flushIFID),
        .redirect       (redirect),
        .redirectPc     (redirectPc),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemAck        (imemAck),
        .imemData       (imemData),
        .instrIFOut     (instrIFOut),
        .pcPlusOneIFOut (pcPlusOneIFOut),
        .validIFOut     (validIFOut)
`ifdef IF_PERF_CNT_EN
        ,
        .fetchCnt       (fetchCnt),
        .discardCnt     (discardCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic flush, input logic redir, input logic [PC_W-1:0] target);
        stallIFID  = stall;
        flushIFID  = flush;
        redirect   = redir;
        redirectPc = target;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [INSTR_W-1:0] instr, input logic [PC_W-1:0] pc1);
        checkOutput({tag, "_valid"}, 32'(validIFOut), 32'd1);
        checkOutput({tag, "_instr"}, 32'(instrIFOut), 32'(instr));
        checkOutput({tag, "_pc1"}, 32'(pcPlusOneIFOut), 32'(pc1));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        autoAck    = 1'b1;
        ackVal     = 1'b0;
        stallIFID  = 1'b0;
        flushIFID  = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;

        // Reset state
        applyStimulus(0, 0, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("rst_req", 32'(imemReq), 32'd0);
        checkOutput("rst_valid", 32'(validIFOut), 32'd0);
        checkOutput("rst_instr", 32'(instrIFOut), 32'd0);
        checkOutput("rst_pc1", 32'(pcPlusOneIFOut), 32'd0);
`ifdef IF_PERF_CNT_EN
        checkOutput("rst_fetchcnt", 32'(fetchCnt), 32'd0);
        checkOutput("rst_discardcnt", 32'(discardCnt), 32'd0);
`endif

        // Zero-wait streaming, one instruction per cycle
        rst = 1'b0;
        #1;
        checkOutput("first_req", 32'(imemReq), 32'd1);
        checkOutput("first_addr", 32'(imemAddr), 32'h000);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("stream0", 19'h00000, 12'h001);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("stream1", 19'h00001, 12'h002);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("stream2", 19'h00002, 12'h003);
        applyStimulus(0, 0, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("stream4", 19'h00004, 12'h005);

        // Three-cycle ack latency at pc=5
        autoAck = 1'b0;
        ackVal  = 1'b0;
        #1;
        checkOutput("wait_addr0", 32'(imemAddr), 32'h005);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("wait_valid1", 32'(validIFOut), 32'd0);
        checkOutput("wait_addr1", 32'(imemAddr), 32'h005);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("wait_valid2", 32'(validIFOut), 32'd0);
        checkOutput("wait_addr2", 32'(imemAddr), 32'h005);
        ackVal = 1'b1;
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("wait_done", 19'h00005, 12'h006);

        // Ack at pc=7 under a two-cycle stall
        ackVal  = 1'b0;
        autoAck = 1'b1;
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("pre_stall", 19'h00006, 12'h007);
        applyStimulus(1, 0, 0, 12'h000);
        checkOutput("hold1_req", 32'(imemReq), 32'd0);
        checkIfId("hold1_frozen", 19'h00006, 12'h007);
        applyStimulus(1, 0, 0, 12'h000);
        checkOutput("hold2_req", 32'(imemReq), 32'd0);
        checkIfId("hold2_frozen", 19'h00006, 12'h007);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("hold_release", 19'h00007, 12'h008);
        checkOutput("hold_next_addr", 32'(imemAddr), 32'h008);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("after_hold", 19'h00008, 12'h009);

        // Redirect to 0x040 while the fetch at 0x010 is still pending
        applyStimulus(0, 0, 1, 12'h010);
        checkOutput("redir_bubble", 32'(validIFOut), 32'd0);
        autoAck = 1'b0;
        ackVal  = 1'b0;
        #1;
        checkOutput("pend_addr", 32'(imemAddr), 32'h010);
        applyStimulus(0, 0, 1, 12'h040);
        checkOutput("disc1_valid", 32'(validIFOut), 32'd0);
        checkOutput("disc1_addr", 32'(imemAddr), 32'h010);
        checkOutput("disc1_req", 32'(imemReq), 32'd1);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("disc2_valid", 32'(validIFOut), 32'd0);
        checkOutput("disc2_addr", 32'(imemAddr), 32'h010);
        ackVal = 1'b1;
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("disc3_valid", 32'(validIFOut), 32'd0);
        checkOutput("target_addr", 32'(imemAddr), 32'h040);
        ackVal  = 1'b0;
        autoAck = 1'b1;
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("target_fetch", 19'h00040, 12'h041);

        // PC wrap at 0xFFF
        applyStimulus(0, 0, 1, 12'hFFF);
        checkOutput("wrap_bubble", 32'(validIFOut), 32'd0);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("wrap_fff", 19'h00FFF, 12'h000);
        checkOutput("wrap_addr", 32'(imemAddr), 32'h000);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("wrap_zero", 19'h00000, 12'h001);

        // Flush together with stall; captured buffer still delivered afterwards
        applyStimulus(1, 1, 0, 12'h000);
        checkOutput("flush_valid", 32'(validIFOut), 32'd0);
        checkOutput("flush_instr", 32'(instrIFOut), 32'd0);
        checkOutput("flush_pc1", 32'(pcPlusOneIFOut), 32'd0);
        checkOutput("flush_hold_req", 32'(imemReq), 32'd0);
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("flush_buffer", 19'h00001, 12'h002);

        // Reset asserted in the middle of a DISCARD
        autoAck = 1'b0;
        ackVal  = 1'b0;
        applyStimulus(0, 0, 1, 12'h100);
        checkOutput("mid_disc_addr", 32'(imemAddr), 32'h002);
        redirect = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("mid_rst_req", 32'(imemReq), 32'd0);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("mid_rst_valid", 32'(validIFOut), 32'd0);
        rst     = 1'b0;
        autoAck = 1'b1;
        #1;
        checkOutput("post_rst_req", 32'(imemReq), 32'd1);
        checkOutput("post_rst_addr", 32'(imemAddr), 32'h000);
`ifdef IF_PERF_CNT_EN
        checkOutput("post_rst_fetchcnt", 32'(fetchCnt), 32'd0);
        checkOutput("post_rst_discardcnt", 32'(discardCnt), 32'd0);
`endif
        applyStimulus(0, 0, 0, 12'h000);
        checkIfId("post_rst_fetch", 19'h00000, 12'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
